// File: rtl/fd_delay_calibrator.sv
// Coarse delay-line calibrator: launches test pulses, times the synchronised echo edge,
// and reports min/max/sum of 2**g_log2_samples round trips in clk_sys_i cycles.
module fd_delay_calibrator #(
  parameter int unsigned g_cnt_width    = 16,
  parameter int unsigned g_log2_samples = 4,
  parameter int unsigned g_pulse_width  = 4,
  parameter int unsigned g_holdoff      = 8,
  parameter int unsigned g_timeout      = 1000
) (
  input  logic                                   clk_sys_i,
  input  logic                                   rst_n_sys_i,
  input  logic                                   start_i,
  output logic                                   pulse_o,
  input  logic                                   echo_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   valid_o,
  output logic                                   timeout_o,
  output logic [g_cnt_width-1:0]                 min_o,
  output logic [g_cnt_width-1:0]                 max_o,
  output logic [g_cnt_width+g_log2_samples-1:0]  sum_o
);

  localparam int unsigned c_sum_width  = g_cnt_width + g_log2_samples;
  localparam int unsigned c_hold_width = $clog2(g_holdoff + 1);
  localparam logic [g_cnt_width-1:0]  c_timeout     = g_cnt_width'(g_timeout);
  localparam logic [g_cnt_width-1:0]  c_pulse_width = g_cnt_width'(g_pulse_width);
  localparam logic [c_hold_width-1:0] c_hold_last   = c_hold_width'(g_holdoff - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ECHO, HOLDOFF, FINISH} state_t;

  state_t                    state_q, state_d;
  logic                      echo_s1_q, echo_s1_d, echo_s2_q, echo_s2_d, echo_prev_q, echo_prev_d;
  logic                      pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
  logic                      valid_q, valid_d, timeout_q, timeout_d;
  logic [g_cnt_width-1:0]    cnt_q, cnt_d, cnt_next;
  logic [c_hold_width-1:0]   hold_q, hold_d;
  logic [g_log2_samples-1:0] idx_q, idx_d;
  logic [g_cnt_width-1:0]    acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [c_sum_width-1:0]    acc_sum_q, acc_sum_d;
  logic [g_cnt_width-1:0]    min_q, min_d, max_q, max_d;
  logic [c_sum_width-1:0]    sum_q, sum_d;
  logic                      echo_rise;

  // Only a fresh rising edge of the synchronised echo counts as a return.
  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign cnt_next  = cnt_q + g_cnt_width'(1);

  always_comb begin
    state_d     = state_q;
    echo_s1_d   = echo_i;
    echo_s2_d   = echo_s1_q;
    echo_prev_d = echo_s2_q;
    pulse_d     = pulse_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    acc_sum_d   = acc_sum_q;
    min_d       = min_q;
    max_d       = max_q;
    sum_d       = sum_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = LAUNCH;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          acc_min_d = '1;
          acc_max_d = '0;
          acc_sum_d = '0;
          idx_d     = '0;
        end
      end
      LAUNCH: begin
        pulse_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        // cnt_next equals the round-trip time including the two synchroniser stages.
        cnt_d = cnt_next;
        if (cnt_next >= c_pulse_width) pulse_d = 1'b0;
        if (echo_rise) begin
          pulse_d   = 1'b0;
          if (cnt_next < acc_min_q) acc_min_d = cnt_next;
          if (cnt_next > acc_max_q) acc_max_d = cnt_next;
          acc_sum_d = acc_sum_q + c_sum_width'(cnt_next);
          idx_d     = idx_q + g_log2_samples'(1);
          hold_d    = '0;
          state_d   = HOLDOFF;
        end else if (cnt_next == c_timeout) begin
          pulse_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      HOLDOFF: begin
        if (echo_s2_q) begin
          hold_d = '0;
        end else if (hold_q == c_hold_last) begin
          state_d = (idx_q == '0) ? FINISH : LAUNCH;
        end else begin
          hold_d = hold_q + c_hold_width'(1);
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!timeout_q) begin
          min_d   = acc_min_q;
          max_d   = acc_max_q;
          sum_d   = acc_sum_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_sys_i) begin
    if (!rst_n_sys_i) begin
      state_q     <= IDLE;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      acc_min_q   <= '0;
      acc_max_q   <= '0;
      acc_sum_q   <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      echo_s1_q   <= echo_s1_d;
      echo_s2_q   <= echo_s2_d;
      echo_prev_q <= echo_prev_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      acc_sum_q   <= acc_sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign min_o     = min_q;
  assign max_o     = max_q;
  assign sum_o     = sum_q;

endmodule

// File: tb/tb_fd_delay_calibrator.sv
// Testbench for fd_delay_calibrator: an echo driver answers each pulse after k cycles and
// results are compared against min/max/sum computed from the k values (sample = k + 2).
module tb_fd_delay_calibrator;

  localparam int CW = 16;
  localparam int LS = 4;
  localparam int PW = 4;
  localparam int HO = 8;
  localparam int TO = 1000;
  localparam int NS = 1 << LS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic           echo_i = 1'b0;
  logic           pulse_o, busy_o, done_o, valid_o, timeout_o;
  logic [CW-1:0]  min_o, max_o;
  logic [CW+LS-1:0] sum_o;

  int             n_cmp = 0;
  int             n_bad = 0;
  int             pulse_rises = 0;
  int             done_seen = 0;
  logic           pulse_prev = 1'b0;
  int             k_q[$];
  logic [CW-1:0]  exp_min, exp_max;
  logic [CW+LS-1:0] exp_sum;

  fd_delay_calibrator #(
    .g_cnt_width(CW), .g_log2_samples(LS), .g_pulse_width(PW),
    .g_holdoff(HO), .g_timeout(TO)
  ) dut (
    .clk_sys_i(clk), .rst_n_sys_i(rst_n), .start_i(start_i), .pulse_o(pulse_o),
    .echo_i(echo_i), .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o),
    .timeout_o(timeout_o), .min_o(min_o), .max_o(max_o), .sum_o(sum_o)
  );

  always #5 clk = ~clk;

  // Counts launches and completion strobes independently of the test flow.
  always @(negedge clk) begin
    if (pulse_o === 1'b1 && pulse_prev === 1'b0) pulse_rises++;
    pulse_prev = pulse_o;
    if (done_o === 1'b1) done_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_pulse_rise(output bit ok);
    logic prev;
    prev = pulse_o;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pulse_o === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = pulse_o;
    end
  endtask

  // Called right after the launch edge: echo is seen by sync stage 1 k edges later.
  task automatic drive_echo(input int k, input int hold);
    repeat (k - 1) step();
    echo_i = 1'b1;
    repeat (hold) step();
    echo_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      cycles++;
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_samples(input int first, output bit ok);
    bit got;
    ok = 1'b1;
    for (int i = first; i < NS; i++) begin
      wait_pulse_rise(got);
      if (!got) begin
        ok = 1'b0;
        return;
      end
      drive_echo(k_q[i], int'($urandom_range(6, 1)));
    end
  endtask

  // Expected results straight from the sample definition.
  task automatic model_run();
    int mn, mx, sm, s;
    mn = 32'h7fffffff;
    mx = 0;
    sm = 0;
    foreach (k_q[i]) begin
      s = k_q[i] + 2;
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      sm += s;
    end
    exp_min = CW'(mn);
    exp_max = CW'(mx);
    exp_sum = (CW+LS)'(sm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({pulse_o, busy_o, done_o, valid_o, timeout_o} !== 5'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {pulse_o, busy_o, done_o, valid_o, timeout_o});
    end
    n_cmp++;
    if ({min_o, max_o, sum_o} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_results: got min %0d max %0d sum %0d expected 0", min_o, max_o, sum_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  // One complete run with the current k_q; checks results, pulse count and done count.
  task automatic check_full_run(input string tag, input int first_sample);
    bit ok;
    int cyc;
    run_samples(first_sample, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL %s_launch: got no pulse_o rise expected one within 200 cycles", tag);
    end
    wait_done(400, ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL %s_done: got no done_o expected done within 400 cycles", tag);
    end
    start_i = 1'b0;
    model_run();
    n_cmp++;
    if (min_o !== exp_min || max_o !== exp_max) begin
      n_bad++;
      $display("[TB] FAIL %s_minmax: got %0d/%0d expected %0d/%0d", tag, min_o, max_o, exp_min, exp_max);
    end
    n_cmp++;
    if (sum_o !== exp_sum) begin
      n_bad++;
      $display("[TB] FAIL %s_sum: got %0d expected %0d", tag, sum_o, exp_sum);
    end
    n_cmp++;
    if ({valid_o, timeout_o, busy_o} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL %s_flags: got valid/timeout/busy %b expected 100", tag, {valid_o, timeout_o, busy_o});
    end
    repeat (3) step();
    n_cmp++;
    if (pulse_rises !== NS || done_seen !== 1) begin
      n_bad++;
      $display("[TB] FAIL %s_counts: got %0d pulses %0d done expected %0d pulses 1 done", tag, pulse_rises, done_seen, NS);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_idle: got busy %b expected 0", tag, busy_o);
    end
  endtask

  task automatic test_fixed_delay(input string tag);
    k_q.delete();
    for (int i = 0; i < NS; i++) k_q.push_back(5);
    pulse_rises = 0;
    done_seen = 0;
    start_run();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s_busy: got %b expected 1", tag, busy_o);
    end
    check_full_run(tag, 0);
  endtask

  task automatic test_alternating();
    k_q.delete();
    for (int i = 0; i < NS; i++) k_q.push_back((i % 2 == 0) ? 3 : 10);
    pulse_rises = 0;
    done_seen = 0;
    start_run();
    check_full_run("alt", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      k_q.delete();
      for (int i = 0; i < NS; i++) k_q.push_back(int'($urandom_range(60, 1)));
      pulse_rises = 0;
      done_seen = 0;
      start_run();
      check_full_run("rand", 0);
    end
  endtask

  // Follows a good run; exp_* still hold that run's expected results.
  task automatic test_timeout();
    bit ok;
    int cyc;
    pulse_rises = 0;
    done_seen = 0;
    echo_i = 1'b0;
    start_run();
    n_cmp++;
    if (valid_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL to_valid_hold: got %b expected 1", valid_o);
    end
    wait_pulse_rise(ok);
    wait_done(1200, ok, cyc);
    n_cmp++;
    if (!ok || cyc < TO || cyc > TO + 2) begin
      n_bad++;
      $display("[TB] FAIL to_latency: got done=%b after %0d cycles expected done after %0d..%0d", ok, cyc, TO, TO + 2);
    end
    n_cmp++;
    if ({timeout_o, valid_o} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL to_flags: got timeout/valid %b expected 11", {timeout_o, valid_o});
    end
    n_cmp++;
    if (min_o !== exp_min || max_o !== exp_max || sum_o !== exp_sum) begin
      n_bad++;
      $display("[TB] FAIL to_hold: got %0d/%0d/%0d expected %0d/%0d/%0d", min_o, max_o, sum_o, exp_min, exp_max, exp_sum);
    end
    repeat (3) step();
    n_cmp++;
    if (pulse_rises !== 1 || done_seen !== 1) begin
      n_bad++;
      $display("[TB] FAIL to_counts: got %0d pulses %0d done expected 1 and 1", pulse_rises, done_seen);
    end
  endtask

  task automatic test_stuck_echo();
    bit ok;
    int p0, c;
    k_q.delete();
    for (int i = 0; i < NS; i++) k_q.push_back(int'($urandom_range(30, 1)));
    pulse_rises = 0;
    done_seen = 0;
    start_run();
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL stuck_to_clear: got %b expected 0", timeout_o);
    end
    for (int i = 0; i < 2; i++) begin
      wait_pulse_rise(ok);
      drive_echo(k_q[i], 2);
    end
    wait_pulse_rise(ok);
    repeat (k_q[2] - 1) step();
    echo_i = 1'b1;
    step();
    p0 = pulse_rises;
    for (int j = 0; j < 60; j++) begin
      start_i = (j % 20 == 10);
      step();
    end
    start_i = 1'b0;
    n_cmp++;
    if (pulse_rises !== p0 || pulse_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stuck_hold: got %0d new pulses pulse %b busy %b expected 0 new pulses pulse 0 busy 1", pulse_rises - p0, pulse_o, busy_o);
    end
    echo_i = 1'b0;
    c = 0;
    for (int j = 1; j <= 50; j++) begin
      step();
      if (pulse_o === 1'b1) begin
        c = j;
        break;
      end
    end
    n_cmp++;
    if (c != HO + 2 && c != HO + 3) begin
      n_bad++;
      $display("[TB] FAIL stuck_release: got pulse after %0d cycles expected %0d or %0d", c, HO + 2, HO + 3);
    end
    drive_echo(k_q[3], 3);
    // start_i stays high through the final holdoff and FINISH and must be ignored.
    start_i = 1'b1;
    check_full_run("stuck", 4);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    start_run();
    wait_pulse_rise(ok);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pulse_o, busy_o, valid_o, done_o} !== 4'b0) begin
      n_bad++;
      $display("[TB] FAIL midrst_flags: got pulse/busy/valid/done %b expected 0000", {pulse_o, busy_o, valid_o, done_o});
    end
    n_cmp++;
    if ({min_o, max_o, sum_o} !== '0) begin
      n_bad++;
      $display("[TB] FAIL midrst_results: got %0d/%0d/%0d expected 0", min_o, max_o, sum_o);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    test_fixed_delay("postrst");
  endtask

  initial begin
    test_reset();
    test_fixed_delay("fixed");
    test_alternating();
    test_random();
    test_timeout();
    test_stuck_echo();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
